// File: rtl/lb_sram_bank.sv
// Line-buffer SRAM bank: NUM_BANK dual-port word arrays with 1-cycle registered reads and idle-address suppression.
// Optional LB_SRAM_COLLISION_CHK_EN adds same-address A/B collision pulse, saturating counter and both-write check.
module lb_sram_bank #(
    parameter int NUM_BANK = 62,
    parameter int DW       = 16,
    parameter int AW       = 10
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_frame_start,
    input  logic [NUM_BANK-1:0] i_sram_WENA,
    input  logic [NUM_BANK-1:0] i_sram_WENB,
    input  logic [DW-1:0]       i_sram_DA [NUM_BANK],
    input  logic [DW-1:0]       i_sram_DB [NUM_BANK],
    input  logic [AW-1:0]       i_sram_AA [NUM_BANK],
    input  logic [AW-1:0]       i_sram_AB [NUM_BANK],
    output logic [DW-1:0]       o_sram_QA [NUM_BANK],
    output logic [DW-1:0]       o_sram_QB [NUM_BANK]
`ifdef LB_SRAM_COLLISION_CHK_EN
    ,
    output logic                o_collision,
    output logic [15:0]         o_collision_cnt
`endif
);

    localparam logic [AW-1:0] IDLE_ADDR = '1;

`ifdef LB_SRAM_COLLISION_CHK_EN
    logic [NUM_BANK-1:0] hit;
    logic [NUM_BANK-1:0] both_wr;
`else
    logic unused_frame_start;
    assign unused_frame_start = i_frame_start;
`endif

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        logic [DW-1:0] mem [2**AW];
        logic [DW-1:0] q_a;
        logic [DW-1:0] q_b;
        logic          a_valid;
        logic          b_valid;

        assign a_valid = (i_sram_AA[b] != IDLE_ADDR);
        assign b_valid = (i_sram_AB[b] != IDLE_ADDR);

        // NOTE: the array has no reset, matching the macro; gating on i_rst_n only drops writes during reset.
        // Port A is written last so it wins a same-address double write.
        always_ff @(posedge i_clk) begin
            if (i_rst_n) begin
                if (b_valid && !i_sram_WENB[b]) mem[i_sram_AB[b]] <= i_sram_DB[b];
                if (a_valid && !i_sram_WENA[b]) mem[i_sram_AA[b]] <= i_sram_DA[b];
            end
        end

        // NOTE: non-blocking reads of mem see the pre-edge contents, giving read-before-write across ports.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                q_a <= '0;
                q_b <= '0;
            end else begin
                if (a_valid && i_sram_WENA[b]) q_a <= mem[i_sram_AA[b]];
                if (b_valid && i_sram_WENB[b]) q_b <= mem[i_sram_AB[b]];
            end
        end

        assign o_sram_QA[b] = q_a;
        assign o_sram_QB[b] = q_b;

`ifdef LB_SRAM_COLLISION_CHK_EN
        assign hit[b]     = a_valid && (i_sram_AA[b] == i_sram_AB[b])
                            && (!i_sram_WENA[b] || !i_sram_WENB[b]);
        assign both_wr[b] = hit[b] && !i_sram_WENA[b] && !i_sram_WENB[b];
`endif
    end

`ifdef LB_SRAM_COLLISION_CHK_EN
    logic any_hit;
    assign any_hit = |hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_collision     <= 1'b0;
            o_collision_cnt <= '0;
        end else begin
            o_collision <= any_hit;
            if (i_frame_start) begin
                o_collision_cnt <= {15'd0, any_hit};
            end else if (any_hit && (o_collision_cnt != 16'hFFFF)) begin
                o_collision_cnt <= o_collision_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (both_wr == '0)
            else $error("lb_sram_bank: both ports wrote the same address, banks=%h", both_wr);
        end
    end
`endif

endmodule

// File: tb/tb_lb_sram_bank.sv
// Directed self-checking bench for lb_sram_bank; collision checks run only when LB_SRAM_COLLISION_CHK_EN is defined.
module tb_lb_sram_bank;

    localparam int NB = 62;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam logic [AW-1:0] IDLE = 10'h3FF;

    logic          clk;
    logic          rst_n;
    logic          frame_start;
    logic [NB-1:0] wena;
    logic [NB-1:0] wenb;
    logic [DW-1:0] da [NB];
    logic [DW-1:0] db [NB];
    logic [AW-1:0] aa [NB];
    logic [AW-1:0] ab [NB];
    logic [DW-1:0] qa [NB];
    logic [DW-1:0] qb [NB];
`ifdef LB_SRAM_COLLISION_CHK_EN
    logic          coll;
    logic [15:0]   coll_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    lb_sram_bank #(.NUM_BANK(NB), .DW(DW), .AW(AW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_frame_start (frame_start),
        .i_sram_WENA   (wena),
        .i_sram_WENB   (wenb),
        .i_sram_DA     (da),
        .i_sram_DB     (db),
        .i_sram_AA     (aa),
        .i_sram_AB     (ab),
        .o_sram_QA     (qa),
        .o_sram_QB     (qb)
`ifdef LB_SRAM_COLLISION_CHK_EN
        ,
        .o_collision     (coll),
        .o_collision_cnt (coll_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < NB; i++) begin
            wena[i] = 1'b1;
            wenb[i] = 1'b1;
            aa[i]   = IDLE;
            ab[i]   = IDLE;
            da[i]   = '0;
            db[i]   = '0;
        end
        frame_start = 1'b0;
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        #3;
        check("reset_qa0", qa[0], 16'h0000);
        check("reset_qb61", qb[61], 16'h0000);
`ifdef LB_SRAM_COLLISION_CHK_EN
        check("reset_coll", {15'd0, coll}, 16'h0000);
        check("reset_cnt", coll_cnt, 16'h0000);
`endif
        step();
        rst_n = 1'b1;
        step();

        // Write bank 5 addr 10 via A; Q must not write through.
        wena[5] = 1'b0; aa[5] = 10'd10; da[5] = 16'h1234;
        step();
        check("no_write_through_qa5", qa[5], 16'h0000);
        idle_all();
        wenb[5] = 1'b1; ab[5] = 10'd10;
        step();
        check("read_b5_a10", qb[5], 16'h1234);
        idle_all();

        // Bank 3: read then idle address holds Q; idle-address write is ignored.
        wena[3] = 1'b0; aa[3] = 10'd7; da[3] = 16'h0777;
        step();
        idle_all();
        ab[3] = 10'd7;
        step();
        check("read_b3_a7", qb[3], 16'h0777);
        idle_all();
        for (int k = 0; k < 4; k++) begin
            step();
            check("idle_hold_qb3", qb[3], 16'h0777);
        end
        wena[3] = 1'b0; aa[3] = IDLE; da[3] = 16'hFFFF;
        step();
        check("idle_write_qa3_hold", qa[3], 16'h0000);
        idle_all();
        aa[3] = 10'd7;
        step();
        check("idle_write_no_change", qa[3], 16'h0777);
        idle_all();

        // Bank 0 addr 20: read-before-write in both directions.
        wena[0] = 1'b0; aa[0] = 10'd20; da[0] = 16'h0AAA;
        step();
        wena[0] = 1'b0; aa[0] = 10'd20; da[0] = 16'h0BBB;
        ab[0] = 10'd20;
        step();
        check("rbw_b_old", qb[0], 16'h0AAA);
        idle_all();
        ab[0] = 10'd20;
        step();
        check("rbw_b_new", qb[0], 16'h0BBB);
        idle_all();
        wenb[0] = 1'b0; ab[0] = 10'd20; db[0] = 16'h0CCC;
        aa[0] = 10'd20;
        step();
        check("rbw_a_old", qa[0], 16'h0BBB);
        idle_all();
        aa[0] = 10'd20;
        step();
        check("rbw_a_new", qa[0], 16'h0CCC);
        idle_all();

        // Both ports write bank 61 addr 0: port A wins.
`ifdef LB_SRAM_COLLISION_CHK_EN
        frame_start = 1'b1;
        step();
        check("frame_clear_cnt", coll_cnt, 16'h0000);
        idle_all();
`endif
        wena[61] = 1'b0; aa[61] = 10'd0; da[61] = 16'h0011;
        wenb[61] = 1'b0; ab[61] = 10'd0; db[61] = 16'h0022;
        step();
`ifdef LB_SRAM_COLLISION_CHK_EN
        check("coll_pulse", {15'd0, coll}, 16'h0001);
        check("coll_cnt_one", coll_cnt, 16'h0001);
`endif
        idle_all();
        aa[61] = 10'd0;
        step();
`ifdef LB_SRAM_COLLISION_CHK_EN
        check("coll_pulse_end", {15'd0, coll}, 16'h0000);
        check("coll_cnt_hold", coll_cnt, 16'h0001);
`endif
        check("both_write_a_wins", qa[61], 16'h0011);
        idle_all();

        // All banks written in one cycle at addr 639, then read back on B.
        for (int i = 0; i < NB; i++) begin
            wena[i] = 1'b0; aa[i] = 10'd639; da[i] = 16'(i);
        end
        step();
        idle_all();
        for (int i = 0; i < NB; i++) ab[i] = 10'd639;
        step();
        for (int i = 0; i < NB; i++) check($sformatf("all_bank_qb%0d", i), qb[i], 16'(i));
        idle_all();

`ifdef LB_SRAM_COLLISION_CHK_EN
        // Saturation: 70000 colliding cycles (A write / B read, no both-write).
        wena[0] = 1'b0; aa[0] = 10'd100; da[0] = 16'h0001; ab[0] = 10'd100;
        for (int k = 0; k < 70000; k++) @(posedge clk);
        #1;
        check("coll_cnt_saturate", coll_cnt, 16'hFFFF);
        idle_all();
        frame_start = 1'b1;
        step();
        check("frame_clear_after_sat", coll_cnt, 16'h0000);
        wena[0] = 1'b0; aa[0] = 10'd100; ab[0] = 10'd100;
        step();
        check("frame_with_coll_loads_one", coll_cnt, 16'h0001);
        idle_all();
        wena[0] = 1'b0; aa[0] = 10'd100; ab[0] = 10'd100;
        step();
        idle_all();
`endif

        // Reset mid-access: Q clears at once, pending write dropped, contents kept.
        check("pre_reset_qb7", qb[7], 16'h0007);
        wena[5] = 1'b0; aa[5] = 10'd10; da[5] = 16'h5555;
        rst_n = 1'b0;
        #1;
        check("mid_reset_qb7", qb[7], 16'h0000);
`ifdef LB_SRAM_COLLISION_CHK_EN
        check("mid_reset_cnt", coll_cnt, 16'h0000);
`endif
        step();
        idle_all();
        rst_n = 1'b1;
        step();
        check("post_reset_qb0", qb[0], 16'h0000);
        ab[5] = 10'd10;
        step();
        check("reset_dropped_write", qb[5], 16'h1234);
        idle_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
